// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port arbiter and burst sequencer for the tagged main-RAM bus.
// Each grant produces an address strobe followed by len+1 read or write beats.
// The RAM auto-increments its address latch on every beat.
// Build option MEMARB_FIXED_PRIO_EN: when defined, port 0 always wins simultaneous
// requests and there is no priority register. The default build uses round-robin.
module mem_bus_arbiter #(
   parameter int ADDR_W = 20,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   input  logic [63:0]       wdata0,
   input  logic [63:0]       wdata1,
   input  logic [7:0]        wtag0,
   input  logic [7:0]        wtag1,
   output logic              ack0,
   output logic              ack1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [63:0]       rdata,
   output logic [7:0]        rtag,
   output logic              done0,
   output logic              done1,
   output logic [63:0]       o_ad,
   output logic [7:0]        o_tag,
   output logic              o_astb,
   output logic              o_rd,
   output logic              o_wr,
   input  logic [63:0]       i_data,
   input  logic [7:0]        i_tag
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_XFER} state_t;

   state_t            state_q;
   logic              port_q;      // granted port
   logic              we_q;        // granted burst direction
   logic [LEN_W-1:0]  cnt_q;       // beats remaining minus one
   logic [1:0]        rv_q;        // read beat returning this cycle, per port
   logic [1:0]        rdone_q;     // that returning beat is the last one
   logic [1:0]        rv_d;
   logic [1:0]        rdone_d;

   logic xfer, last, wr_beat, rd_beat;
   logic elig0, elig1, gnt_vld, gnt_port;

   assign xfer    = (state_q == S_XFER);
   assign last    = (cnt_q == '0);
   assign wr_beat = xfer & we_q;
   assign rd_beat = xfer & ~we_q;

   // A port whose done pulses now is held off until the next IDLE cycle.
   assign elig0   = req0 & ~done0;
   assign elig1   = req1 & ~done1;
   assign gnt_vld = elig0 | elig1;

`ifdef MEMARB_FIXED_PRIO_EN
   assign gnt_port = ~elig0;
`else
   logic prio_q;   // port that wins the next contested grant

   assign gnt_port = (elig0 & elig1) ? prio_q : elig1;

   // Round-robin: after each grant the other port gets priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             prio_q <= 1'b0;
      else if (state_q == S_IDLE && gnt_vld) prio_q <= ~gnt_port;
   end
`endif

   // Read returns are registered copies of read XFER cycles (RAM latency is one cycle).
   always_comb begin
      rv_d    = {rd_beat & port_q, rd_beat & ~port_q};
      rdone_d = rv_d & {2{last}};
   end

   // Burst sequencer: IDLE -> ADDR -> XFER x (len+1) -> IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
         rv_q    <= '0;
         rdone_q <= '0;
      end else begin
         rv_q    <= rv_d;
         rdone_q <= rdone_d;
         case (state_q)
            S_IDLE: begin
               if (gnt_vld) begin
                  state_q <= S_ADDR;
                  port_q  <= gnt_port;
                  we_q    <= gnt_port ? we1 : we0;
                  cnt_q   <= gnt_port ? len1 : len0;
               end
            end
            S_ADDR: state_q <= S_XFER;
            S_XFER: begin
               if (last) state_q <= S_IDLE;
               else      cnt_q   <= cnt_q - LEN_W'(1);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Bus data path: address in ADDR, write beat in write XFER, zero otherwise.
   always_comb begin
      o_ad  = '0;
      o_tag = '0;
      if (state_q == S_ADDR) begin
         o_ad = 64'(port_q ? addr1 : addr0);
      end else if (wr_beat) begin
         o_ad  = port_q ? wdata1 : wdata0;
         o_tag = port_q ? wtag1 : wtag0;
      end
   end

   assign o_astb  = (state_q == S_ADDR);
   assign o_wr    = wr_beat;
   assign o_rd    = rd_beat;
   assign ack0    = wr_beat & ~port_q;
   assign ack1    = wr_beat & port_q;
   assign rvalid0 = rv_q[0];
   assign rvalid1 = rv_q[1];
   assign done0   = (wr_beat & last & ~port_q) | rdone_q[0];
   assign done1   = (wr_beat & last & port_q) | rdone_q[1];
   assign rdata   = i_data;
   assign rtag    = i_tag;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed tests with an expected-event scoreboard.
// Stimulus pushes the bus events it expects; a negedge monitor pops and compares.
module tb_mem_bus_arbiter;
   localparam int AW = 20;
   localparam int LW = 4;
   localparam logic [63:0] IDLE_DATA = 64'hDEAD_BEEF_0BAD_F00D;

   logic clk = 1'b0;
   logic reset;
   logic req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [LW-1:0] len0, len1;
   logic [63:0] wdata0 = '0, wdata1 = '0;
   logic [7:0]  wtag0 = '0, wtag1 = '0;
   logic ack0, ack1, rvalid0, rvalid1, done0, done1;
   logic [63:0] rdata, o_ad;
   logic [7:0]  rtag, o_tag;
   logic o_astb, o_rd, o_wr;
   logic [63:0] i_data = IDLE_DATA;
   logic [7:0]  i_tag = 8'hEE;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(AW), .LEN_W(LW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
      .wdata0(wdata0), .wdata1(wdata1), .wtag0(wtag0), .wtag1(wtag1),
      .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .rtag(rtag), .done0(done0), .done1(done1),
      .o_ad(o_ad), .o_tag(o_tag), .o_astb(o_astb), .o_rd(o_rd), .o_wr(o_wr),
      .i_data(i_data), .i_tag(i_tag)
   );

   // kind: 0 = address strobe, 1 = write beat, 2 = read return
   typedef struct {
      int          kind;
      int          port;
      logic [63:0] data;
      logic [7:0]  tag;
      logic        done;
      int          dly;   // cycles since previous event, -1 = don't care
   } ev_t;

   ev_t q[$];
   int total = 0, bad = 0, cyc = 0, last_cyc = 0;
   int nack0 = 0, nack1 = 0;
   logic [63:0] wbase0 = '0, wbase1 = '0;
   logic [7:0]  wtbase0 = '0, wtbase1 = '0;
   logic [63:0] mem  [0:4095];
   logic [7:0]  tmem [0:4095];

   function automatic logic [63:0] pre(input int a);
      return 64'hF000_0000_0000_0000 | 64'(a);
   endfunction
   function automatic logic [7:0] ptag(input int a);
      return 8'(a) ^ 8'h5A;
   endfunction

   task automatic push(input int k, input int p, input logic [63:0] d, input logic [7:0] t,
                       input logic dn, input int dly);
      ev_t e;
      e.kind = k; e.port = p; e.data = d; e.tag = t; e.done = dn; e.dly = dly;
      q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic check_ev(input int k, input int p, input logic [63:0] d, input logic [7:0] t);
      ev_t e;
      logic dn, od;
      dn = (p == 1) ? done1 : done0;
      od = (p == 1) ? done0 : done1;
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event cyc=%0d kind=%0d port=%0d data=%h", cyc, k, p, d);
      end else begin
         e = q.pop_front();
         if (e.kind != k || e.port != p || e.data !== d || e.tag !== t || e.done !== dn || od !== 1'b0) begin
            bad++;
            $display("FAIL bus_event cyc=%0d act k=%0d p=%0d d=%h t=%h dn=%b odn=%b exp k=%0d p=%0d d=%h t=%h dn=%b",
                     cyc, k, p, d, t, dn, od, e.kind, e.port, e.data, e.tag, e.done);
         end
         if (e.dly >= 0) begin
            total++;
            if (cyc - last_cyc != e.dly) begin
               bad++;
               $display("FAIL event_spacing cyc=%0d act=%0d exp=%0d", cyc, cyc - last_cyc, e.dly);
            end
         end
      end
      last_cyc = cyc;
   endtask

   // Monitor: samples DUT outputs mid-cycle.
   initial forever begin
      @(negedge clk);
      cyc++;
      if (ack0) nack0++;
      if (ack1) nack1++;
      if ((int'(o_astb) + int'(o_rd) + int'(o_wr)) > 1 || (rvalid0 && rvalid1)) begin
         total++; bad++;
         $display("FAIL strobe_excl cyc=%0d astb=%b rd=%b wr=%b rv=%b%b", cyc, o_astb, o_rd, o_wr, rvalid1, rvalid0);
      end
      if ((done0 || done1) && !(rvalid0 || rvalid1 || o_wr)) begin
         total++; bad++;
         $display("FAIL stray_done cyc=%0d act=%b%b exp=00", cyc, done1, done0);
      end
      if ((ack0 || ack1) && !o_wr) begin
         total++; bad++;
         $display("FAIL stray_ack cyc=%0d act=%b%b exp=00", cyc, ack1, ack0);
      end
      if (rvalid0 || rvalid1) check_ev(2, rvalid1 ? 1 : 0, rdata, rtag);
      if (o_astb)             check_ev(0, 0, o_ad, o_tag);
      if (o_wr)               check_ev(1, ack1 ? 1 : (ack0 ? 0 : -1), o_ad, o_tag);
   end

   // Write requesters: present the next beat on the cycle after each ack.
   initial forever begin
      @(posedge clk); #1;
      wdata0 = wbase0 + 64'(nack0);
      wtag0  = wtbase0 + 8'(nack0);
      wdata1 = wbase1 + 64'(nack1);
      wtag1  = wtbase1 + 8'(nack1);
   end

   // RAM model: auto-incrementing latch, read data valid the cycle after o_rd.
   initial begin
      logic [11:0] lat;
      logic        rpend;
      logic [63:0] rbuf;
      logic [7:0]  rtbuf;
      lat = '0; rpend = 1'b0; rbuf = '0; rtbuf = '0;
      forever begin
         @(negedge clk);
         rpend = 1'b0;
         if (!reset) begin
            if (o_astb) lat = o_ad[11:0];
            if (o_wr) begin
               mem[lat] = o_ad; tmem[lat] = o_tag; lat = lat + 12'd1;
            end
            if (o_rd) begin
               rbuf = mem[lat]; rtbuf = tmem[lat]; rpend = 1'b1; lat = lat + 12'd1;
            end
         end
         @(posedge clk); #1;
         i_data = rpend ? rbuf : IDLE_DATA;
         i_tag  = rpend ? rtbuf : 8'hEE;
      end
   end

   task automatic set_w(input int p, input logic [63:0] d, input logic [7:0] t);
      if (p == 0) begin wbase0 = d - 64'(nack0); wtbase0 = t - 8'(nack0); end
      else        begin wbase1 = d - 64'(nack1); wtbase1 = t - 8'(nack1); end
   endtask

   // which: 0 = done0, 1 = done1, 2 = ack0
   task automatic wait_for(input int which, input string nm);
      int  n;
      logic s;
      n = 0;
      s = 1'b0;
      while (!s && n < 200) begin
         @(negedge clk);
         n++;
         s = (which == 0) ? done0 : (which == 1) ? done1 : ack0;
      end
      total++;
      if (!s) begin
         bad++;
         $display("FAIL timeout_%s act=no_pulse exp=pulse", nm);
      end
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain_%s act=%0d_pending exp=0", nm, q.size());
         q.delete();
      end
   endtask

   initial begin
      int ord[4];
      int n0, n1, p;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = pre(i); tmem[i] = ptag(i);
      end
      reset = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_strobes", 64'({o_astb, o_rd, o_wr}), 64'd0);
      chk("rst_ctl", 64'({ack0, ack1, rvalid0, rvalid1, done0, done1}), 64'd0);
      chk("rst_ad_tag", o_ad | 64'(o_tag), 64'd0);
      chk("rst_rdata", rdata, IDLE_DATA);

      // Simultaneous 1-beat write requests from reset
      we0 = 1; we1 = 1; addr0 = 20'h200; addr1 = 20'h300; len0 = 0; len1 = 0;
      set_w(0, 64'h1111_0000, 8'h10);
      set_w(1, 64'h2222_0000, 8'h20);
`ifdef MEMARB_FIXED_PRIO_EN
      ord = '{0, 0, 1, 1};
`else
      ord = '{0, 1, 0, 1};
`endif
      n0 = 0; n1 = 0;
      for (int i = 0; i < 4; i++) begin
         p = ord[i];
         push(0, 0, (p == 1) ? 64'h300 : 64'h200, 8'h0, 1'b0, (i == 0) ? -1 : 2);
         if (p == 0) begin push(1, 0, 64'h1111_0000 + 64'(n0), 8'h10 + 8'(n0), 1'b1, 1); n0++; end
         else        begin push(1, 1, 64'h2222_0000 + 64'(n1), 8'h20 + 8'(n1), 1'b1, 1); n1++; end
      end
      req0 = 1; req1 = 1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_for(ord[i], "simul");
`ifdef MEMARB_FIXED_PRIO_EN
         if (i == 1) req0 = 0;
`endif
      end
      req0 = 0; req1 = 0;
      drain("simul");

      // Single 4-beat write on port 0
      we0 = 1; addr0 = 20'h100; len0 = 3;
      set_w(0, 64'hA0, 8'h50);
      push(0, 0, 64'h100, 8'h0, 1'b0, -1);
      for (int k = 0; k < 4; k++) push(1, 0, 64'hA0 + 64'(k), 8'h50 + 8'(k), k == 3, 1);
      req0 = 1;
      wait_for(0, "wr4");
      req0 = 0;
      drain("wr4");
      for (int k = 0; k < 4; k++) begin
         chk("ram_wr4_data", mem[12'h100 + 12'(k)], 64'hA0 + 64'(k));
         chk("ram_wr4_tag", 64'(tmem[12'h100 + 12'(k)]), 64'h50 + 64'(k));
      end

      // Readback on port 1
      we1 = 0; addr1 = 20'h100; len1 = 3;
      push(0, 0, 64'h100, 8'h0, 1'b0, -1);
      for (int k = 0; k < 4; k++) push(2, 1, 64'hA0 + 64'(k), 8'h50 + 8'(k), k == 3, (k == 0) ? 2 : 1);
      req1 = 1;
      wait_for(1, "rd4");
      req1 = 0;
      drain("rd4");

      // Back-to-back: 16-beat read on port 0, then a 2-beat write on port 1
      we0 = 0; addr0 = 20'h400; len0 = 15;
      we1 = 1; addr1 = 20'h500; len1 = 1;
      set_w(1, 64'hB0, 8'h70);
      push(0, 0, 64'h400, 8'h0, 1'b0, -1);
      for (int k = 0; k < 16; k++) push(2, 0, pre(16'h400 + k), ptag(16'h400 + k), k == 15, (k == 0) ? 2 : 1);
      push(0, 0, 64'h500, 8'h0, 1'b0, 1);
      push(1, 1, 64'hB0, 8'h70, 1'b0, 1);
      push(1, 1, 64'hB1, 8'h71, 1'b1, 1);
      req0 = 1; req1 = 1;
      wait_for(0, "b2b_rd");
      req0 = 0;
      wait_for(1, "b2b_wr");
      req1 = 0;
      drain("b2b");
      chk("ram_b2b_0", mem[12'h500], 64'hB0);
      chk("ram_b2b_1", mem[12'h501], 64'hB1);

      // Grant gate: req0 still high in the cycle its read done pulses
      we0 = 0; addr0 = 20'h420; len0 = 0;
      push(0, 0, 64'h420, 8'h0, 1'b0, -1);
      push(2, 0, pre(16'h420), ptag(16'h420), 1'b1, 2);
      req0 = 1;
      wait_for(0, "gate");
      @(negedge clk);
      req0 = 0;
      drain("gate");

      // Early req drop after the first ack of a 4-beat write
      we0 = 1; addr0 = 20'h600; len0 = 3;
      set_w(0, 64'hC0, 8'h30);
      push(0, 0, 64'h600, 8'h0, 1'b0, -1);
      for (int k = 0; k < 4; k++) push(1, 0, 64'hC0 + 64'(k), 8'h30 + 8'(k), k == 3, 1);
      req0 = 1;
      wait_for(2, "drop_ack");
      req0 = 0;
      wait_for(0, "drop_done");
      drain("drop");
      chk("ram_drop_last", mem[12'h603], 64'hC3);

      // Reset during beat 2 of an 8-beat write
      we0 = 1; addr0 = 20'h700; len0 = 7;
      set_w(0, 64'hD0, 8'h40);
      push(0, 0, 64'h700, 8'h0, 1'b0, -1);
      push(1, 0, 64'hD0, 8'h40, 1'b0, 1);
      push(1, 0, 64'hD1, 8'h41, 1'b0, 1);
      req0 = 1;
      wait_for(2, "mid_ack0");
      wait_for(2, "mid_ack1");
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_ctl", 64'({o_astb, o_rd, o_wr, ack0, ack1, rvalid0, rvalid1, done0, done1}), 64'd0);
      chk("mid_rst_ad_tag", o_ad | 64'(o_tag), 64'd0);
      req0 = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_pending", 64'(q.size()), 64'd0);
      q.delete();
      chk("ram_mid_b0", mem[12'h700], 64'hD0);
      chk("ram_mid_b1", mem[12'h701], 64'hD1);
      chk("ram_mid_b2", mem[12'h702], pre(16'h702));
      chk("ram_mid_b7", mem[12'h707], pre(16'h707));

      // Port 0 has priority again after reset
      we0 = 1; we1 = 1; addr0 = 20'h800; addr1 = 20'h900; len0 = 0; len1 = 0;
      set_w(0, 64'hE0, 8'h60);
      set_w(1, 64'hF0, 8'h61);
      push(0, 0, 64'h800, 8'h0, 1'b0, -1);
      push(1, 0, 64'hE0, 8'h60, 1'b1, 1);
      push(0, 0, 64'h900, 8'h0, 1'b0, 2);
      push(1, 1, 64'hF0, 8'h61, 1'b1, 1);
      req0 = 1; req1 = 1;
      wait_for(0, "post_rst0");
      req0 = 0;
      wait_for(1, "post_rst1");
      req1 = 0;
      drain("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
